// File: rtl/ram_port_arbiter_if.sv
// Purpose: one master's request/response bundle toward the RAM port arbiter.
// Latency: gnt is same-cycle combinational; rvalid/rdata/err follow one cycle after gnt.
// Backpressure: the master holds req until gnt; responses are never stalled.
interface ram_port_arbiter_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  size;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;

    modport master (
        output req, we, addr, wdata, size,
        input  gnt, rvalid, rdata, err
    );

    modport slave (
        input  req, we, addr, wdata, size,
        output gnt, rvalid, rdata, err
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// Purpose: shares one single-port RAM between fetch (m0) and load/store (m1), screening each access.
// Latency: grant and RAM strobes in cycle N, registered response pulse in N+1.
// Backpressure: losing master simply keeps req high; m0 is forced through after STARVE_MAX losses.
module ram_port_arbiter #(
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter int unsigned STARVE_MAX  = 4
) (
    input  logic                clk,
    input  logic                rst,
    ram_port_arbiter_if.slave   m0,
    ram_port_arbiter_if.slave   m1,
    output logic [31:0]         mem_addr_o,
    output logic [31:0]         mem_data_o,
    output logic                mem_we_o,
    output logic                mem_re_o,
    output logic [2:0]          mem_size_o,
    input  logic [31:0]         mem_data_i
);

    localparam int unsigned CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] STARVE_MAX_C = CW'(STARVE_MAX);
    // Compared at 33 bits so a 4 GiB RAM cannot wrap the limit to zero.
    localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH_WORDS) * 33'd4;

    logic [CW-1:0] starve_cnt_q, starve_cnt_d;
    logic          resp_valid_q, resp_valid_d;
    logic          resp_owner_q, resp_owner_d;
    logic          resp_err_q,   resp_err_d;
    logic          resp_load_q,  resp_load_d;

    logic          gnt0, gnt1, any_gnt;
    logic          sel_we;
    logic [31:0]   sel_addr, sel_wdata;
    logic [2:0]    sel_size;
    logic          acc_err;
    logic [31:0]   resp_rdata;

    // Arbitration: m1 has priority unless m0 has lost STARVE_MAX contended cycles in a row.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst) begin
            if (m0.req && m1.req) begin
                gnt0 = (starve_cnt_q == STARVE_MAX_C);
                gnt1 = !gnt0;
            end else begin
                gnt0 = m0.req;
                gnt1 = m1.req;
            end
        end
    end

    assign m0.gnt  = gnt0;
    assign m1.gnt  = gnt1;
    assign any_gnt = gnt0 | gnt1;

    // Steer the granted master's access fields onto a common path.
    always_comb begin
        sel_we    = gnt1 ? m1.we    : m0.we;
        sel_addr  = gnt1 ? m1.addr  : m0.addr;
        sel_wdata = gnt1 ? m1.wdata : m0.wdata;
        sel_size  = gnt1 ? m1.size  : m0.size;
    end

    // Screen the selected access for alignment, store-size legality and range.
    always_comb begin
        acc_err = 1'b0;
        case (sel_size)
            3'd0:    acc_err = 1'b0;
            3'd1:    acc_err = sel_addr[0];
            3'd2:    acc_err = |sel_addr[1:0];
            3'd3:    acc_err = sel_we;
            3'd4:    acc_err = sel_addr[0] | sel_we;
            default: acc_err = 1'b1;
        endcase
        if ({1'b0, sel_addr} >= ADDR_LIMIT) begin
            acc_err = 1'b1;
        end
    end

    // Drive the RAM port; rejected accesses carry address/data but no strobe.
    always_comb begin
        mem_addr_o = '0;
        mem_data_o = '0;
        mem_size_o = '0;
        mem_we_o   = 1'b0;
        mem_re_o   = 1'b0;
        if (any_gnt) begin
            mem_addr_o = sel_addr;
            mem_data_o = sel_wdata;
            mem_size_o = sel_size;
            mem_we_o   = sel_we  && !acc_err;
            mem_re_o   = !sel_we && !acc_err;
        end
    end

    // Next-state: starvation counter and the one-deep response pipeline stage.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!m0.req || gnt0) begin
            starve_cnt_d = '0;
        end else if (gnt1 && (starve_cnt_q != STARVE_MAX_C)) begin
            starve_cnt_d = starve_cnt_q + CW'(1);
        end
        resp_valid_d = any_gnt;
        resp_owner_d = gnt1;
        resp_err_d   = any_gnt && acc_err;
        resp_load_d  = any_gnt && !sel_we;
    end

    // State register; reset drops any response still in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt_q <= '0;
            resp_valid_q <= 1'b0;
            resp_owner_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_load_q  <= 1'b0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            resp_valid_q <= resp_valid_d;
            resp_owner_q <= resp_owner_d;
            resp_err_q   <= resp_err_d;
            resp_load_q  <= resp_load_d;
        end
    end

    // Route the registered response to its owner; everything else reads zero.
    always_comb begin
        resp_rdata = (resp_valid_q && resp_load_q && !resp_err_q) ? mem_data_i : 32'd0;
        m0.rvalid  = resp_valid_q && !resp_owner_q;
        m0.err     = resp_valid_q && !resp_owner_q && resp_err_q;
        m0.rdata   = (resp_valid_q && !resp_owner_q) ? resp_rdata : 32'd0;
        m1.rvalid  = resp_valid_q && resp_owner_q;
        m1.err     = resp_valid_q && resp_owner_q && resp_err_q;
        m1.rdata   = (resp_valid_q && resp_owner_q) ? resp_rdata : 32'd0;
    end

endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Two-master arbiter and access sequencer placed in front of the single-port data/instruction RAM. It shares one RAM port between the instruction-fetch master (m0) and the load/store master (m1). It checks each access for alignment, size and range before issuing it, and tracks the RAM's 1-cycle synchronous read latency. Each accepted access produces exactly one registered response pulse to its owner.

## Interface
Parameters:
- DEPTH_WORDS, 4096: RAM depth in 32-bit words; byte addresses ≥ DEPTH_WORDS*4 are out of range.
- STARVE_MAX, 4: consecutive contended cycles m0 may lose before it is forced to win.

Ports:
- clk  in  1  single clock, all logic rising-edge.
- rst  in  1  reset; synchronous, active-high.
- m0_req_i / m1_req_i  in  1  access request, held until granted.
- m0_we_i / m1_we_i  in  1  1 = store, 0 = load.
- m0_addr_i / m1_addr_i  in  32  byte address.
- m0_wdata_i / m1_wdata_i  in  32  store data, right-aligned.
- m0_size_i / m1_size_i  in  3  0 = LB/SB, 1 = LH/SH, 2 = LW/SW, 3 = LBU, 4 = LHU.
- m0_gnt_o / m1_gnt_o  out  1  combinational grant; the request is consumed this cycle.
- m0_rvalid_o / m1_rvalid_o  out  1  registered response pulse for a granted access.
- m0_rdata_o / m1_rdata_o  out  32  load data, valid with rvalid; 0 otherwise.
- m0_err_o / m1_err_o  out  1  with rvalid: the access was rejected and the RAM was not touched.
- mem_addr_o  out  32  to RAM byte address.
- mem_data_o  out  32  to RAM write data.
- mem_we_o  out  1  to RAM write enable.
- mem_re_o  out  1  to RAM read enable.
- mem_size_o  out  3  to RAM size code.
- mem_data_i  in  32  from RAM; registered read data, 1 cycle after mem_re_o.

## Operation
- Arbitration runs every cycle. Exactly one of m0_gnt_o or m1_gnt_o may be high, or neither.
  - Only one master requesting: that master is granted.
  - Both requesting: m1 wins, unless starve_cnt == STARVE_MAX, in which case m0 wins.
- starve_cnt, 0..STARVE_MAX:
  - Increments when both masters request and m1 is granted.
  - Clears when m0 is granted or m0_req_i = 0.
  - Saturates at STARVE_MAX.
- Each grant is classified as follows.
  - Error when any of these holds:
    - size 1 or 4 with addr[0] = 1;
    - size 2 with addr[1:0] ≠ 0;
    - store with size 3 or 4;
    - size 5..7;
    - addr ≥ DEPTH_WORDS*4.
  - On error: mem_we_o = mem_re_o = 0 this cycle.
  - Valid load: mem_re_o = 1.
  - Valid store: mem_we_o = 1.
  - mem_addr_o, mem_data_o and mem_size_o come from the granted master. They are 0 when nothing is granted.
- Response register, captured at each granted edge: resp_valid, resp_owner (0/1), resp_err, resp_load.
  - Next cycle, the owner's rvalid_o = 1 and err_o = resp_err.
  - rdata_o = mem_data_i only if resp_load and !resp_err; otherwise 0.
  - The non-owner's outputs stay 0.
- Stores and errored accesses also produce one rvalid pulse, which acts as the acknowledge.
- Back-to-back grants are allowed every cycle, and the responses pipeline 1:1.

## Timing
- Cycle N: req high and selected, so gnt and the mem_* strobes are high combinationally in N.
- Cycle N+1: rvalid/err/rdata are presented for the N access.
- Load-to-use latency is 1 cycle. A store in N is visible to a load granted in N+1.
- Reset (rst high at an edge):
  - resp_valid = 0, starve_cnt = 0.
  - All rvalid/err/rdata outputs are 0 in the following cycle.
  - A response pending at reset is dropped and never delivered.
- While rst is high, gnt_o and the mem_* strobes are forced to 0.
- The same master holding req across cycles gets one grant per cycle. Each grant is a separate access; the master must update or drop req after gnt.

## Test plan
- m1 LW at 0x10 with RAM word 0xDEADBEEF, m0 idle:
  - m1_gnt in N, mem_re_o = 1, mem_size_o = 2.
  - m1_rvalid = 1 and m1_rdata = 0xDEADBEEF in N+1; m0 outputs stay 0.
- m1 SH 0x1234 at 0x22 in N, m1 LHU 0x22 in N+1:
  - N: mem_we_o = 1.
  - N+1: write ack.
  - N+2: m1_rdata = 0x00001234.
- Misaligned LW at 0x6, SH at 0x3, SB to 0x4000 (DEPTH_WORDS = 4096):
  - Each is granted with no mem strobe.
  - Next cycle: rvalid = 1, err = 1, rdata = 0.
- Both masters request continuously, STARVE_MAX = 4: grants are m1, m1, m1, m1, m0, and the pattern repeats. m0 is never denied more than 4 cycles in a row.
- m0 LW granted in N, rst high at the N edge: no m0_rvalid in N+1; starve_cnt reads 0 and outputs are 0.
- Alternating m0 LW 0x0 / m1 LW 0x4 every cycle, words 0x11111111 / 0x22222222:
  - Every response goes to the correct owner with the correct data.
  - rvalid is never asserted on both masters in the same cycle.
